// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_pkg: opcode constants, decode FSM state encoding and helpers.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam logic [3:0] OPC_ADDI = 4'h5;
  localparam logic [3:0] OPC_LD   = 4'h6;
  localparam logic [3:0] OPC_LDI  = 4'hF;

  typedef enum logic [1:0] {
    S_WORD1 = 2'd0,
    S_IMM   = 2'd1,
    S_HOLD  = 2'd2
  } dec_state_t;

  function automatic logic [15:0] sext4(input logic [3:0] nib);
    return {{12{nib[3]}}, nib};
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_imm.sv
// +--------------------------------------------------------------------+
// | decode_imm: single-word immediate generation from opcode + MBR[3:0]|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module decode_imm
  import cpu_pkg::*;
(
  input  logic [3:0]  i_opc,
  input  logic [3:0]  i_nib,
  output logic [15:0] o_imm
);

  always_comb begin
    o_imm = 16'h0000;
    if (i_opc == OPC_ADDI || i_opc == OPC_LD) begin
      o_imm = sext4(i_nib);
    end
  end

endmodule

`default_nettype wire

// File: rtl/decode.sv
// +--------------------------------------------------------------------+
// | decode: instruction decode stage with LDI two-word support.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module decode
  import cpu_pkg::*;
#(
  parameter int          WORD_W       = 16,
  parameter logic [15:0] ILL_OPC_MASK = 16'h0C00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] i_mbr,
  input  logic              i_mbr_valid,
  output logic              o_in_ready,
  input  logic              i_flush,
  input  logic              i_ex_ready,
  output logic              o_dec_valid,
  output logic [3:0]        o_opc,
  output logic [3:0]        o_rd,
  output logic [3:0]        o_rs1,
  output logic [3:0]        o_rs2,
  output logic [WORD_W-1:0] o_imm,
  output logic              o_illegal
);

  dec_state_t        r_state;
  dec_state_t        w_state_nxt;
  logic [3:0]        r_opc;
  logic [3:0]        r_rd;
  logic [3:0]        r_rs1;
  logic [3:0]        r_rs2;
  logic [WORD_W-1:0] r_imm;
  logic              r_illegal;
  logic              w_in_ready;
  logic              w_take;
  logic [15:0]       w_imm;

  assign w_in_ready = (r_state != S_HOLD);
  assign w_take     = i_mbr_valid & w_in_ready;

  decode_imm u_imm (
    .i_opc (i_mbr[15:12]),
    .i_nib (i_mbr[3:0]),
    .o_imm (w_imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WORD1;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = S_WORD1;
    end else begin
      case (r_state)
        S_WORD1: if (w_take) w_state_nxt = (i_mbr[15:12] == OPC_LDI) ? S_IMM : S_HOLD;
        S_IMM:   if (w_take) w_state_nxt = S_HOLD;
        S_HOLD:  if (i_ex_ready) w_state_nxt = S_WORD1;
        default: w_state_nxt = S_WORD1;
      endcase
    end
  end

  // A flush drops the offered word, so fields only load on an unflushed transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opc     <= 4'h0;
      r_rd      <= 4'h0;
      r_rs1     <= 4'h0;
      r_rs2     <= 4'h0;
      r_imm     <= '0;
      r_illegal <= 1'b0;
    end else if (w_take && !i_flush) begin
      if (r_state == S_IMM) begin
        r_imm <= i_mbr;
      end else begin
        r_opc     <= i_mbr[15:12];
        r_rd      <= i_mbr[11:8];
        r_rs1     <= i_mbr[7:4];
        r_rs2     <= i_mbr[3:0];
        r_imm     <= WORD_W'(w_imm);
        r_illegal <= ILL_OPC_MASK[i_mbr[15:12]];
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_dec_valid = (r_state == S_HOLD);
  assign o_opc       = r_opc;
  assign o_rd        = r_rd;
  assign o_rs1       = r_rs1;
  assign o_rs2       = r_rs2;
  assign o_imm       = r_imm;
  assign o_illegal   = r_illegal;

endmodule

`default_nettype wire
